// File: rtl/traffic_ctrl.sv
// traffic_ctrl -- two-direction intersection controller with walker lamps.
//
// Purpose:
//    Cycles the horizontal (H) and vertical (V) car lamps through
//    GREEN -> YELLOW -> LEFT -> YELLOW for each direction in turn. The walker
//    crossing parallel to the green direction shows GREEN, then GREEN_TWINKLE
//    for the last TWINKLE_T cycles of that green. An optional night mode
//    flashes both car lamps YELLOW/OFF.
//
// Configuration macro:
//    TRAFFIC_NIGHT_EN  -- when defined, i_night can move the FSM into NIGHT
//                         at the end of V_YEL2. When undefined, i_night is
//                         ignored and the OFF lamp code never appears.
//
// Ports:
//    clk                 in   rising-edge clock
//    reset_n             in   asynchronous active-low reset
//    i_night             in   night-mode request (level)
//    o_h_car_traffic     out  [2:0] horizontal car lamp code
//    o_v_car_traffic     out  [2:0] vertical car lamp code
//    o_h_walker_traffic  out  [2:0] horizontal crossing walker lamp code
//    o_v_walker_traffic  out  [2:0] vertical crossing walker lamp code
//    o_phase             out  [3:0] current FSM state encoding
//
// Lamp codes: RED=000 GREEN=001 YELLOW=010 LEFT=011 GREEN_TWINKLE=100 OFF=101
// All outputs decode only registered state, so i_night never reaches them
// combinationally.

module traffic_ctrl #(
   parameter int GREEN_T   = 20,
   parameter int YELLOW_T  = 2,
   parameter int LEFT_T    = 10,
   parameter int TWINKLE_T = 6,
   parameter int FLASH_T   = 4,
   parameter int CW        = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       i_night,
   output logic [2:0] o_h_car_traffic,
   output logic [2:0] o_v_car_traffic,
   output logic [2:0] o_h_walker_traffic,
   output logic [2:0] o_v_walker_traffic,
   output logic [3:0] o_phase
);

   localparam logic [2:0] LAMP_RED     = 3'b000;
   localparam logic [2:0] LAMP_GREEN   = 3'b001;
   localparam logic [2:0] LAMP_YELLOW  = 3'b010;
   localparam logic [2:0] LAMP_LEFT    = 3'b011;
   localparam logic [2:0] LAMP_TWINKLE = 3'b100;
`ifdef TRAFFIC_NIGHT_EN
   localparam logic [2:0] LAMP_OFF     = 3'b101;
`endif

   typedef enum logic [3:0] {
      H_GREEN = 4'd0,
      H_YEL1  = 4'd1,
      H_LEFT  = 4'd2,
      H_YEL2  = 4'd3,
      V_GREEN = 4'd4,
      V_YEL1  = 4'd5,
      V_LEFT  = 4'd6,
      V_YEL2  = 4'd7,
      NIGHT   = 4'd8
   } state_e;

   // Walker GREEN portion of a car GREEN phase; the remainder twinkles.
   localparam logic [CW-1:0] WALK_SOLID = CW'(GREEN_T - TWINKLE_T);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          last_s;

   // Final counter value of each state. LEFT states are unreachable when
   // LEFT_T is 0, so their value then only has to be well-formed.
   function automatic logic [CW-1:0] last_cnt(input state_e s);
      logic [CW-1:0] v;
      case (s)
         H_GREEN, V_GREEN: v = CW'(GREEN_T - 1);
         H_YEL1, H_YEL2,
         V_YEL1, V_YEL2:   v = CW'(YELLOW_T - 1);
         H_LEFT, V_LEFT:   v = (LEFT_T > 0) ? CW'(LEFT_T - 1) : {CW{1'b0}};
         NIGHT:            v = CW'(FLASH_T - 1);
         default:          v = {CW{1'b0}};
      endcase
      return v;
   endfunction

   // Walker lamp for the crossing parallel to the active green direction.
   function automatic logic [2:0] walker_lamp(input logic [CW-1:0] c);
      return (c < WALK_SOLID) ? LAMP_GREEN : LAMP_TWINKLE;
   endfunction

`ifdef TRAFFIC_NIGHT_EN
   // In NIGHT the counter times one half-period; this bit says which half.
   logic flash_off_q, flash_off_d;
`else
   logic unused_night_s;
   assign unused_night_s = i_night;
`endif

   assign last_s = (cnt_q == last_cnt(state_q));

   // State, phase counter and flash half-period registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= H_GREEN;
         cnt_q       <= {CW{1'b0}};
`ifdef TRAFFIC_NIGHT_EN
         flash_off_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
`ifdef TRAFFIC_NIGHT_EN
         flash_off_q <= flash_off_d;
`endif
      end
   end

   // Next-state logic: advance only on the last cycle of the current state.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + CW'(1);
`ifdef TRAFFIC_NIGHT_EN
      flash_off_d = flash_off_q;
`endif
      if (last_s) begin
         cnt_d = {CW{1'b0}};
         case (state_q)
            H_GREEN: state_d = H_YEL1;
            H_YEL1:  state_d = (LEFT_T == 0) ? V_GREEN : H_LEFT;
            H_LEFT:  state_d = H_YEL2;
            H_YEL2:  state_d = V_GREEN;
            V_GREEN: state_d = V_YEL1;
            V_YEL1:  state_d = (LEFT_T == 0) ? H_GREEN : V_LEFT;
            V_LEFT:  state_d = V_YEL2;
`ifdef TRAFFIC_NIGHT_EN
            // i_night is only looked at here, so mid-phase toggles are inert.
            V_YEL2: begin
               state_d     = i_night ? NIGHT : H_GREEN;
               flash_off_d = 1'b0;
            end
            // Leave NIGHT only after a complete OFF half with i_night low.
            NIGHT: begin
               if (flash_off_q && !i_night) begin
                  state_d     = H_GREEN;
                  flash_off_d = 1'b0;
               end else begin
                  flash_off_d = ~flash_off_q;
               end
            end
`else
            V_YEL2:  state_d = H_GREEN;
            NIGHT:   state_d = H_GREEN;
`endif
            default: state_d = H_GREEN;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Lamp decode from registered state and counter.
   always_comb begin
      o_h_car_traffic    = LAMP_RED;
      o_v_car_traffic    = LAMP_RED;
      o_h_walker_traffic = LAMP_RED;
      o_v_walker_traffic = LAMP_RED;
      o_phase            = state_q;
      case (state_q)
         H_GREEN: begin
            o_h_car_traffic    = LAMP_GREEN;
            o_v_walker_traffic = walker_lamp(cnt_q);
         end
         H_YEL1, H_YEL2: o_h_car_traffic = LAMP_YELLOW;
         H_LEFT:         o_h_car_traffic = LAMP_LEFT;
         V_GREEN: begin
            o_v_car_traffic    = LAMP_GREEN;
            o_h_walker_traffic = walker_lamp(cnt_q);
         end
         V_YEL1, V_YEL2: o_v_car_traffic = LAMP_YELLOW;
         V_LEFT:         o_v_car_traffic = LAMP_LEFT;
`ifdef TRAFFIC_NIGHT_EN
         NIGHT: begin
            o_h_car_traffic    = flash_off_q ? LAMP_OFF : LAMP_YELLOW;
            o_v_car_traffic    = flash_off_q ? LAMP_OFF : LAMP_YELLOW;
            o_h_walker_traffic = LAMP_OFF;
            o_v_walker_traffic = LAMP_OFF;
         end
`endif
         default: o_phase = state_q;
      endcase
   end

endmodule

// File: tb/tb_traffic_ctrl.sv
// Self-checking bench for traffic_ctrl. Two instances run side by side:
// [0] default parameters, [1] GREEN_T=5 YELLOW_T=1 LEFT_T=0 TWINKLE_T=2.
// A model keyed on "cycles since start of the day sequence" (or since NIGHT
// entry) predicts every output on every falling edge; hand-computed literal
// pins at chosen cycles of instance [0] anchor the model.
module tb_traffic_ctrl;

   localparam logic [2:0] RED = 3'd0, GRN = 3'd1, YEL = 3'd2,
                          LFT = 3'd3, TWK = 3'd4, OFF = 3'd5;
`ifdef TRAFFIC_NIGHT_EN
   localparam bit NIGHT_EN = 1'b1;
`else
   localparam bit NIGHT_EN = 1'b0;
`endif
   localparam int FL = 4;

   int pg [2] = '{20, 5};
   int py [2] = '{2, 1};
   int pl [2] = '{10, 0};
   int pt [2] = '{6, 2};

   logic       clk = 1'b0;
   logic       reset_n;
   logic       i_night;
   logic [2:0] hc [2];
   logic [2:0] vc [2];
   logic [2:0] hw [2];
   logic [2:0] vw [2];
   logic [3:0] ph [2];

   int m_t     [2];
   bit m_night [2];
   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   traffic_ctrl u_dut0 (
      .clk(clk), .reset_n(reset_n), .i_night(i_night),
      .o_h_car_traffic(hc[0]), .o_v_car_traffic(vc[0]),
      .o_h_walker_traffic(hw[0]), .o_v_walker_traffic(vw[0]),
      .o_phase(ph[0])
   );

   traffic_ctrl #(.GREEN_T(5), .YELLOW_T(1), .LEFT_T(0), .TWINKLE_T(2)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .i_night(i_night),
      .o_h_car_traffic(hc[1]), .o_v_car_traffic(vc[1]),
      .o_h_walker_traffic(hw[1]), .o_v_walker_traffic(vw[1]),
      .o_phase(ph[1])
   );

   function automatic int period(input int k);
      return 2 * (pg[k] + py[k] + ((pl[k] > 0) ? (pl[k] + py[k]) : 0));
   endfunction

   // Expected day-mode outputs for position t within the day sequence.
   task automatic exp_day(input int k, input int t,
                          output logic [2:0] ehc, output logic [2:0] evc,
                          output logic [2:0] ehw, output logic [2:0] evw,
                          output logic [3:0] eph);
      int half, p, seg;
      logic [2:0] lamp, walk;
      bit vdir;
      half = period(k) / 2;
      vdir = (t >= half);
      p    = vdir ? (t - half) : t;
      walk = RED;
      if (p < pg[k]) begin
         lamp = GRN; seg = 0;
         walk = (p < pg[k] - pt[k]) ? GRN : TWK;
      end else if (p < pg[k] + py[k]) begin
         lamp = YEL; seg = 1;
      end else if (p < pg[k] + py[k] + pl[k]) begin
         lamp = LFT; seg = 2;
      end else begin
         lamp = YEL; seg = 3;
      end
      ehc = vdir ? RED : lamp;
      evc = vdir ? lamp : RED;
      ehw = vdir ? walk : RED;
      evw = vdir ? RED : walk;
      eph = 4'(seg + (vdir ? 4 : 0));
   endtask

   task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Literal pin on instance 0.
   task automatic pin(input string nm, input logic [2:0] eh, input logic [2:0] ev,
                      input logic [2:0] ehw_, input logic [2:0] evw_, input logic [3:0] ep);
      chk({nm, ".h_car"},  {1'b0, hc[0]}, {1'b0, eh});
      chk({nm, ".v_car"},  {1'b0, vc[0]}, {1'b0, ev});
      chk({nm, ".h_walk"}, {1'b0, hw[0]}, {1'b0, ehw_});
      chk({nm, ".v_walk"}, {1'b0, vw[0]}, {1'b0, evw_});
      chk({nm, ".phase"},  ph[0], ep);
   endtask

   task automatic adv(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   // Model: position in the day sequence or in NIGHT, per instance.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < 2; k++) begin
            m_t[k]     <= 0;
            m_night[k] <= 1'b0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (!m_night[k]) begin
               if (m_t[k] == period(k) - 1) begin
                  m_t[k] <= 0;
                  if (NIGHT_EN && i_night) m_night[k] <= 1'b1;
               end else begin
                  m_t[k] <= m_t[k] + 1;
               end
            end else begin
               if ((m_t[k] % (2 * FL)) == 2 * FL - 1 && !i_night) begin
                  m_t[k]     <= 0;
                  m_night[k] <= 1'b0;
               end else begin
                  m_t[k] <= m_t[k] + 1;
               end
            end
         end
      end
   end

   // Compare every output of both instances against the model each cycle.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         logic [2:0] ehc, evc, ehw, evw;
         logic [3:0] eph;
         if (m_night[k]) begin
            ehc = ((m_t[k] / FL) % 2 == 0) ? YEL : OFF;
            evc = ehc;
            ehw = OFF;
            evw = OFF;
            eph = 4'd8;
         end else begin
            exp_day(k, m_t[k], ehc, evc, ehw, evw, eph);
         end
         chk($sformatf("model%0d.h_car", k),  {1'b0, hc[k]}, {1'b0, ehc});
         chk($sformatf("model%0d.v_car", k),  {1'b0, vc[k]}, {1'b0, evc});
         chk($sformatf("model%0d.h_walk", k), {1'b0, hw[k]}, {1'b0, ehw});
         chk($sformatf("model%0d.v_walk", k), {1'b0, vw[k]}, {1'b0, evw});
         chk($sformatf("model%0d.phase", k),  ph[k], eph);
      end
   end

   initial begin
      bit found;
      reset_n = 1'b0;
      i_night = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      pin("reset", GRN, RED, RED, GRN, 4'd0);
      reset_n = 1'b1;
      pin("c0", GRN, RED, RED, GRN, 4'd0);
      adv(10);
      i_night = 1'b1;                       // mid-phase toggle, must be inert
      adv(3);
      i_night = 1'b0;
      pin("c13", GRN, RED, RED, GRN, 4'd0);
      adv(6);  pin("c19", GRN, RED, RED, TWK, 4'd0);
      adv(1);  pin("c20", YEL, RED, RED, RED, 4'd1);
      adv(2);  pin("c22", LFT, RED, RED, RED, 4'd2);
      adv(10); pin("c32", YEL, RED, RED, RED, 4'd3);
      adv(2);  pin("c34", RED, GRN, GRN, RED, 4'd4);
      adv(5);
      i_night = 1'b1;                       // raised at cycle 40
      adv(9);  pin("c48", RED, GRN, TWK, RED, 4'd4);
      adv(19); pin("c67", RED, YEL, RED, RED, 4'd7);
      adv(1);
`ifdef TRAFFIC_NIGHT_EN
      pin("c68", YEL, YEL, OFF, OFF, 4'd8);
      adv(4);  pin("c72", OFF, OFF, OFF, OFF, 4'd8);
      adv(6);
      i_night = 1'b0;
      adv(5);  pin("c83", OFF, OFF, OFF, OFF, 4'd8);
      adv(1);  pin("c84", GRN, RED, RED, GRN, 4'd0);
`else
      pin("c68", GRN, RED, RED, GRN, 4'd0);
      adv(4);  pin("c72", GRN, RED, RED, GRN, 4'd0);
      adv(11); pin("c83", GRN, RED, RED, TWK, 4'd0);
      adv(1);  pin("c84", GRN, RED, RED, TWK, 4'd0);
`endif
      // Find the middle of V_LEFT, then pulse reset between clock edges.
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (!m_night[0] && m_t[0] >= 58 && m_t[0] <= 63) found = 1'b1;
      end
      if (!found) begin
         n_chk++;
         n_fail++;
         $display("FAIL vleft_wait: got timeout expected V_LEFT within 200 cycles");
      end
      pin("vleft", RED, LFT, RED, RED, 4'd6);
      #2;
      reset_n = 1'b0;
      #1;
      pin("async_rst", GRN, RED, RED, GRN, 4'd0);
      chk("async_rst.dut1_phase", ph[1], 4'd0);
      @(posedge clk);
      @(negedge clk);
      #1;
      reset_n = 1'b1;
      pin("r0", GRN, RED, RED, GRN, 4'd0);
      adv(19); pin("r19", GRN, RED, RED, TWK, 4'd0);
      adv(1);  pin("r20", YEL, RED, RED, RED, 4'd1);
      adv(48); pin("r68", GRN, RED, RED, GRN, 4'd0);
      adv(68); pin("r136", GRN, RED, RED, GRN, 4'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
